// File: rtl/text_render_pkg.sv
// Shared constants, FSM state type and glyph helpers for the text line renderer.
package text_render_pkg;

    localparam int         CHAR_W      = 8;
    localparam int         CHAR_H      = 16;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } line_state_e;

    function automatic logic is_printable(input logic [6:0] code);
        return (code >= ASCII_SPACE) && (code <= ASCII_TILDE);
    endfunction

    // 'A' carries a real glyph; every other printable code shows a hollow box.
    function automatic logic [7:0] font_row(input logic [6:0] code, input logic [3:0] row);
        logic [7:0] bits;
        bits = 8'h00;
        if (code == 7'h41) begin
            case (row)
                4'd2:                      bits = 8'h10;
                4'd3:                      bits = 8'h38;
                4'd4:                      bits = 8'h6C;
                4'd7:                      bits = 8'hFE;
                4'd5, 4'd6, 4'd8, 4'd9,
                4'd10, 4'd11:              bits = 8'hC6;
                default:                   bits = 8'h00;
            endcase
        end else if ((code == ASCII_SPACE) || !is_printable(code)) begin
            bits = 8'h00;
        end else begin
            case (row)
                4'd2, 4'd13:               bits = 8'h7E;
                4'd3, 4'd4, 4'd5, 4'd6,
                4'd7, 4'd8, 4'd9, 4'd10,
                4'd11, 4'd12:              bits = 8'h42;
                default:                   bits = 8'h00;
            endcase
        end
        return bits;
    endfunction

endpackage

// File: rtl/ascii_rom.sv
// Glyph ROM: address {code, row}, one registered row of 8 pixels, MSB leftmost.
module ascii_rom
    import text_render_pkg::*;
(
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    // Synchronous read, one cycle of latency.
    always_ff @(posedge clk) begin
        data <= font_row(addr[10:4], addr[3:0]);
    end

endmodule

// File: rtl/text_line_render.sv
// Single text line overlay: character cell buffer, write/clear FSM and pixel pipeline.
// Optional blinking underline cursor is built when TEXT_CURSOR_EN is defined.
module text_line_render
    import text_render_pkg::*;
#(
    parameter int         NUM_CHARS    = 16,
    parameter int         ORIGIN_X     = 192,
    parameter int         ORIGIN_Y     = 208,
    parameter logic [7:0] FG_COLOR     = 8'h0F,
    parameter logic [7:0] BG_COLOR     = 8'hFF,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             video_on,
    input  logic [9:0]                       x,
    input  logic [9:0]                       y,
    input  logic                             char_valid,
    input  logic [6:0]                       char_data,
    output logic                             char_ready,
    input  logic                             clear,
    output logic [$clog2(NUM_CHARS+1)-1:0]   cursor_pos,
    output logic [7:0]                       rgb
);

    localparam int              CW       = $clog2(NUM_CHARS + 1);
    localparam int              IW       = $clog2(NUM_CHARS);
    localparam logic [CW-1:0]   CUR_FULL = CW'(NUM_CHARS);
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_CHARS - 1);
    localparam logic [10:0]     X_LO     = 11'(ORIGIN_X);
    localparam logic [10:0]     X_HI     = 11'(ORIGIN_X + CHAR_W * NUM_CHARS);
    localparam logic [10:0]     Y_LO     = 11'(ORIGIN_Y);
    localparam logic [10:0]     Y_HI     = 11'(ORIGIN_Y + CHAR_H);

    line_state_e     state_r, state_nxt_s;
    logic [IW-1:0]   sweep_r, sweep_nxt_s;
    logic [CW-1:0]   cursor_r, cursor_nxt_s;
    logic            ready_r, ready_nxt_s;
    logic            accept_s;
    logic            wr_en_s;
    logic [IW-1:0]   wr_idx_s;
    logic [6:0]      wr_data_s;
    logic [6:0]      cells_r [NUM_CHARS];

    // Clear outranks a coincident write, so it blocks acceptance.
    assign accept_s   = char_valid && ready_r && !clear;
    assign char_ready = ready_r;
    assign cursor_pos = cursor_r;

    // Next-state, cell write port and ready decode.
    always_comb begin
        state_nxt_s  = state_r;
        sweep_nxt_s  = sweep_r;
        cursor_nxt_s = cursor_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = sweep_r;
        wr_data_s    = ASCII_SPACE;
        if (clear) begin
            state_nxt_s  = ST_CLEAR;
            sweep_nxt_s  = '0;
            cursor_nxt_s = '0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    wr_en_s = 1'b1;
                    if (sweep_r == LAST_IDX) begin
                        state_nxt_s = ST_IDLE;
                        sweep_nxt_s = '0;
                    end else begin
                        sweep_nxt_s = sweep_r + IW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept_s && is_printable(char_data)) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = cursor_r[IW-1:0];
                        wr_data_s    = char_data;
                        cursor_nxt_s = cursor_r + CW'(1);
                    end else if (accept_s && (char_data == ASCII_BS) && (cursor_r != '0)) begin
                        wr_en_s      = 1'b1;
                        wr_idx_s     = IW'(cursor_r - CW'(1));
                        cursor_nxt_s = cursor_r - CW'(1);
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s  = ST_CLEAR;
                    sweep_nxt_s  = '0;
                    cursor_nxt_s = '0;
                end
            endcase
        end
        ready_nxt_s = (state_nxt_s == ST_IDLE) && (cursor_nxt_s != CUR_FULL);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_CLEAR;
            sweep_r  <= '0;
            cursor_r <= '0;
            ready_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sweep_r  <= sweep_nxt_s;
            cursor_r <= cursor_nxt_s;
            ready_r  <= ready_nxt_s;
        end
    end

    // Cell storage; contents are rebuilt by the sweep after every reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            cells_r[wr_idx_s] <= wr_data_s;
        end
    end

    logic            in_win_s;
    logic [IW+2:0]   x_off_s;
    logic [IW-1:0]   col_s;
    logic [7:0]      glyph_s;
    logic            cur_hit_s;

    assign in_win_s = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                      ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
    assign x_off_s  = (IW + 3)'({1'b0, x} - X_LO);
    assign col_s    = in_win_s ? x_off_s[IW+2:3] : '0;

    ascii_rom u_rom (
        .clk  (clk),
        .addr ({cells_r[col_s], y[3:0]}),
        .data (glyph_s)
    );

`ifdef TEXT_CURSOR_EN
    localparam int            BW         = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt_r;
    logic          blink_phase_r;
    logic          frame_tick_s;

    assign frame_tick_s = (x == 10'd0) && (y == 10'd0);

    // Frame counter flipping the cursor phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b1;
        end else if (frame_tick_s) begin
            if (blink_cnt_r == BLINK_LAST) begin
                blink_cnt_r   <= '0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_cnt_r <= blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_r <= blink_cnt_r;
        end
    end

    assign cur_hit_s = blink_phase_r && in_win_s && (cursor_r != CUR_FULL) &&
                       (CW'(col_s) == cursor_r) && (y[3:0] >= 4'd14);
`else
    assign cur_hit_s = 1'b0;
`endif

    logic       win_d1_r, cur_d1_r, von_d1_r;
    logic [2:0] xsub_d1_r;
    logic [7:0] pix_s;

    // Colour select for the pixel whose glyph row is leaving the ROM.
    always_comb begin
        pix_s = BG_COLOR;
        if (!von_d1_r) begin
            pix_s = 8'h00;
        end else if (win_d1_r && (glyph_s[3'd7 - xsub_d1_r] || cur_d1_r)) begin
            pix_s = FG_COLOR;
        end else begin
            pix_s = BG_COLOR;
        end
    end

    // Side-band stage aligned with the ROM, then the registered colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_d1_r  <= 1'b0;
            cur_d1_r  <= 1'b0;
            von_d1_r  <= 1'b0;
            xsub_d1_r <= 3'd0;
            rgb       <= 8'h00;
        end else begin
            win_d1_r  <= in_win_s;
            cur_d1_r  <= cur_hit_s;
            von_d1_r  <= video_on;
            xsub_d1_r <= x_off_s[2:0];
            rgb       <= pix_s;
        end
    end

endmodule
